// File: rtl/change_capture_if.sv
// Record stream from the change-capture front end to the SPI transmitter.
// The producer drives valid and the head record; the consumer drives ready.
interface change_capture_if #(
    parameter int WIDTH = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_pins;
    logic [31:0]      out_time;

    modport master (
        output out_valid,
        output out_pins,
        output out_time,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_pins,
        input  out_time,
        output out_ready
    );
endinterface

// File: rtl/change_capture.sv
// Logic analyzer input capture: two-flop synchronizer on the probe pins, a
// free-running cycle counter, change detection, and a first-word-fall-through
// FIFO of {pins, timestamp} records feeding a valid/ready consumer.
module change_capture #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_values,
    change_capture_if.master out,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int RW = WIDTH + 32;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] s1_reg;
    logic [WIDTH-1:0] s2_reg;
    logic [WIDTH-1:0] prev_reg;
    logic [31:0]      now_reg;
    // Post-release edge counter: 0..2 while warming up, 3 once running.
    logic [1:0]       start_reg;

    logic [RW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             overflow_reg;

    logic             snapshot;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;
    logic             write_en;
    logic [RW-1:0]    head;

    // The snapshot edge is the third one after release; change detection
    // runs on every edge after it, comparing against the previous s2.
    assign snapshot = (start_reg == 2'd2);
    assign push     = snapshot || ((start_reg == 2'd3) && (s2_reg != prev_reg));
    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_FULL);
    assign pop      = !empty && out.out_ready;
    // A full FIFO still accepts a record when the head leaves the same cycle.
    assign write_en = push && (!full || pop);

    // Synchronizer, timestamp counter, change tracking and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_reg       <= '0;
            s2_reg       <= '0;
            prev_reg     <= '0;
            now_reg      <= '0;
            start_reg    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            s1_reg  <= pin_values;
            s2_reg  <= s1_reg;
            now_reg <= now_reg + 32'd1;
            if (start_reg != 2'd3) begin
                start_reg <= start_reg + 2'd1;
            end
            if (start_reg >= 2'd2) begin
                prev_reg <= s2_reg;
            end
            if (write_en) begin
                wr_ptr_reg <= wr_ptr_reg + (AW)'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + (AW)'(1);
            end
            case ({write_en, pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
            if (push && full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Record storage; the record carries the values held before the push edge.
    always_ff @(posedge clk) begin
        if (rst && write_en) begin
            mem[wr_ptr_reg] <= {s2_reg, now_reg};
        end
    end

    // Head of queue falls through; outputs are forced to zero when empty.
    assign head          = mem[rd_ptr_reg];
    assign out.out_valid = !empty;
    assign out.out_pins  = empty ? '0 : head[RW-1:32];
    assign out.out_time  = empty ? '0 : head[31:0];
    assign overflow      = overflow_reg;
endmodule
